// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
//   Real-time clock/calendar core. A prescaler divides clk down to a
//   one-second tick that advances a binary hh:mm:ss dd/mm/yyyy register set
//   with Gregorian leap-year handling. A RUN/SET state machine lets three
//   debounced push-buttons edit any field while the clock is frozen.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   set_mode   in   level: 1 = SET (edit), 0 = RUN
//   btn_inc    in   debounced level, increments selected field on rising edge
//   btn_dec    in   debounced level, decrements selected field on rising edge
//   btn_next   in   debounced level, advances field selection on rising edge
//   sec        out  seconds 0..59
//   min        out  minutes 0..59
//   hour       out  hours 0..23
//   day        out  day of month 1..days_in_month
//   month      out  month 1..12
//   year       out  year 0..9999
//   field_sel  out  edited field: 0 hour, 1 min, 2 sec, 3 day, 4 month, 5 year
//   editing    out  high while in SET
//   tick       out  one-cycle pulse in the cycle a RUN-mode second update shows

module rtc_calendar_core #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int RESET_YEAR  = 2024,
    parameter int RESET_MONTH = 1,
    parameter int RESET_DAY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_next,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [13:0] year,
    output logic [2:0]  field_sel,
    output logic        editing,
    output logic        tick
);

    localparam int              PS_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PS_W-1:0] r_ps;
    logic [5:0]      r_sec;
    logic [5:0]      r_min;
    logic [4:0]      r_hour;
    logic [4:0]      r_day;
    logic [3:0]      r_month;
    logic [13:0]     r_year;
    logic [2:0]      r_fsel;
    logic            r_edit;
    logic            r_tick;
    logic            r_inc_h;
    logic            r_dec_h;
    logic            r_next_h;

    logic [PS_W-1:0] w_ps_nxt;
    logic [5:0]      w_sec_nxt;
    logic [5:0]      w_min_nxt;
    logic [4:0]      w_hour_nxt;
    logic [4:0]      w_day_nxt;
    logic [3:0]      w_month_nxt;
    logic [13:0]     w_year_nxt;
    logic [2:0]      w_fsel_nxt;
    logic            w_edit_nxt;
    logic            w_tick_nxt;

    logic            w_inc_edge;
    logic            w_dec_edge;
    logic            w_next_edge;
    logic            w_up;
    logic [4:0]      w_dim_cur;
    logic [3:0]      w_month_step;
    logic [13:0]     w_year_step;

    // Gregorian leap rule; year 0 is divisible by 400 and therefore leap.
    function automatic logic is_leap(input logic [13:0] y);
        return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) ||
               ((y % 14'd400) == 14'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                 input logic [13:0] y);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Step within [lo, hi] and wrap by equality against the limits, so the
    // register width never decides where a field wraps.
    function automatic logic [13:0] step_wrap(input logic [13:0] v,
                                              input logic [13:0] lo,
                                              input logic [13:0] hi,
                                              input logic        up);
        logic [13:0] r;
        if (up) r = (v == hi) ? lo : v + 14'd1;
        else    r = (v == lo) ? hi : v - 14'd1;
        return r;
    endfunction

    function automatic logic [4:0] clamp_day(input logic [4:0] d,
                                             input logic [4:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign w_inc_edge  = btn_inc  & ~r_inc_h;
    assign w_dec_edge  = btn_dec  & ~r_dec_h;
    assign w_next_edge = btn_next & ~r_next_h;
    assign w_up        = w_inc_edge;

    assign w_dim_cur    = days_in_month(r_month, r_year);
    assign w_month_step = 4'(step_wrap({10'd0, r_month}, 14'd1, 14'd12, w_up));
    assign w_year_step  = step_wrap(r_year, 14'd0, 14'd9999, w_up);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUN) begin
            if (set_mode) w_state_nxt = ST_SET;
        end else begin
            if (!set_mode) w_state_nxt = ST_RUN;
        end
    end

    // Datapath next values: tick carry chain in RUN, button edits in SET
    always_comb begin
        w_ps_nxt    = r_ps;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_day_nxt   = r_day;
        w_month_nxt = r_month;
        w_year_nxt  = r_year;
        w_fsel_nxt  = r_fsel;
        w_edit_nxt  = r_edit;
        w_tick_nxt  = 1'b0;

        if (r_state == ST_RUN) begin
            if (set_mode) begin
                w_ps_nxt   = '0;
                w_fsel_nxt = 3'd0;
                w_edit_nxt = 1'b1;
            end else if (r_ps == PS_MAX) begin
                w_ps_nxt   = '0;
                w_tick_nxt = 1'b1;
                // Whole carry chain resolves in this one edge.
                if (r_sec == 6'd59) begin
                    w_sec_nxt = 6'd0;
                    if (r_min == 6'd59) begin
                        w_min_nxt = 6'd0;
                        if (r_hour == 5'd23) begin
                            w_hour_nxt = 5'd0;
                            if (r_day == w_dim_cur) begin
                                w_day_nxt = 5'd1;
                                if (r_month == 4'd12) begin
                                    w_month_nxt = 4'd1;
                                    w_year_nxt  = (r_year == 14'd9999) ? 14'd0
                                                                       : r_year + 14'd1;
                                end else begin
                                    w_month_nxt = r_month + 4'd1;
                                end
                            end else begin
                                w_day_nxt = r_day + 5'd1;
                            end
                        end else begin
                            w_hour_nxt = r_hour + 5'd1;
                        end
                    end else begin
                        w_min_nxt = r_min + 6'd1;
                    end
                end else begin
                    w_sec_nxt = r_sec + 6'd1;
                end
            end else begin
                w_ps_nxt = r_ps + PS_W'(1);
            end
        end else begin
            if (!set_mode) begin
                w_ps_nxt   = '0;
                w_edit_nxt = 1'b0;
            end else begin
                if (w_next_edge)
                    w_fsel_nxt = (r_fsel >= 3'd5) ? 3'd0 : r_fsel + 3'd1;

                // Simultaneous inc and dec cancel; the edit uses the old field_sel.
                if (w_inc_edge ^ w_dec_edge) begin
                    case (r_fsel)
                        3'd0: w_hour_nxt = 5'(step_wrap({9'd0, r_hour}, 14'd0, 14'd23, w_up));
                        3'd1: w_min_nxt  = 6'(step_wrap({8'd0, r_min},  14'd0, 14'd59, w_up));
                        3'd2: w_sec_nxt  = 6'(step_wrap({8'd0, r_sec},  14'd0, 14'd59, w_up));
                        3'd3: w_day_nxt  = 5'(step_wrap({9'd0, r_day},  14'd1,
                                                        {9'd0, w_dim_cur}, w_up));
                        3'd4: begin
                            w_month_nxt = w_month_step;
                            w_day_nxt   = clamp_day(r_day, days_in_month(w_month_step, r_year));
                        end
                        3'd5: begin
                            w_year_nxt = w_year_step;
                            w_day_nxt  = clamp_day(r_day, days_in_month(r_month, w_year_step));
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Registered datapath and button history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps     <= '0;
            r_sec    <= 6'd0;
            r_min    <= 6'd0;
            r_hour   <= 5'd0;
            r_day    <= 5'(RESET_DAY);
            r_month  <= 4'(RESET_MONTH);
            r_year   <= 14'(RESET_YEAR);
            r_fsel   <= 3'd0;
            r_edit   <= 1'b0;
            r_tick   <= 1'b0;
            r_inc_h  <= 1'b0;
            r_dec_h  <= 1'b0;
            r_next_h <= 1'b0;
        end else begin
            r_ps     <= w_ps_nxt;
            r_sec    <= w_sec_nxt;
            r_min    <= w_min_nxt;
            r_hour   <= w_hour_nxt;
            r_day    <= w_day_nxt;
            r_month  <= w_month_nxt;
            r_year   <= w_year_nxt;
            r_fsel   <= w_fsel_nxt;
            r_edit   <= w_edit_nxt;
            r_tick   <= w_tick_nxt;
            r_inc_h  <= btn_inc;
            r_dec_h  <= btn_dec;
            r_next_h <= btn_next;
        end
    end

    assign sec       = r_sec;
    assign min       = r_min;
    assign hour      = r_hour;
    assign day       = r_day;
    assign month     = r_month;
    assign year      = r_year;
    assign field_sel = r_fsel;
    assign editing   = r_edit;
    assign tick      = r_tick;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb_rtc_calendar_core
//   Directed bench for rtc_calendar_core with CLK_DIV = 4. Inputs are
//   driven and outputs sampled on the falling clock edge.

module tb_rtc_calendar_core;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        btn_next = 1'b0;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;
    logic [2:0]  field_sel;
    logic        editing;
    logic        tick;

    int n_cmp = 0;
    int n_bad = 0;

    rtc_calendar_core #(
        .CLK_DIV    (CLK_DIV),
        .RESET_YEAR (2024),
        .RESET_MONTH(1),
        .RESET_DAY  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_mode (set_mode),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .btn_next (btn_next),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .day      (day),
        .month    (month),
        .year     (year),
        .field_sel(field_sel),
        .editing  (editing),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, 32'(hour), 32'(h));
        chk({tag, ".min"},  32'(min),  32'(m));
        chk({tag, ".sec"},  32'(sec),  32'(s));
    endtask

    task automatic chk_date(input string tag, input int d, input int mo, input int y);
        chk({tag, ".day"},   32'(day),   32'(d));
        chk({tag, ".month"}, 32'(month), 32'(mo));
        chk({tag, ".year"},  32'(year),  32'(y));
    endtask

    // Reset with set_mode preset; returns on the falling edge that releases reset.
    task automatic do_reset(input logic sm);
        @(negedge clk);
        rst_n = 1'b0; set_mode = sm;
        btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Each press: one cycle high, one cycle low.
    task automatic press(input logic i, input logic d, input logic n, input int cnt);
        repeat (cnt) begin
            @(negedge clk);
            btn_inc = i; btn_dec = d; btn_next = n;
            @(negedge clk);
            btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0;
        end
    endtask

    // Leave SET and expect the first tick exactly CLK_DIV edges after the exit edge.
    task automatic exit_and_tick(input string tag, input int d, input int mo, input int y);
        int early;
        early = 0;
        @(negedge clk);
        set_mode = 1'b0;
        @(negedge clk);
        chk({tag, ".editing_after_exit"}, 32'(editing), 32'd0);
        for (int k = 1; k < CLK_DIV; k++) begin
            @(negedge clk);
            if (tick) early++;
        end
        chk({tag, ".early_tick"}, 32'(early), 32'd0);
        @(negedge clk);
        chk({tag, ".tick"}, 32'(tick), 32'd1);
        chk_time(tag, 0, 0, 0);
        chk_date(tag, d, mo, y);
        @(negedge clk);
        chk({tag, ".tick_one_cycle"}, 32'(tick), 32'd0);
    endtask

    // Build 23:59:59 28/02/(2024 - ydec) from the reset value, then roll over.
    task automatic leap_case(input string tag, input int ydec,
                             input int d, input int mo, input int y);
        do_reset(1'b1);
        press(0, 1, 0, 1);  press(0, 0, 1, 1);   // hour 23
        press(0, 1, 0, 1);  press(0, 0, 1, 1);   // min 59
        press(0, 1, 0, 1);  press(0, 0, 1, 1);   // sec 59
        press(1, 0, 0, 27); press(0, 0, 1, 1);   // day 28
        press(1, 0, 0, 1);  press(0, 0, 1, 1);   // month 2
        press(0, 1, 0, ydec);
        chk_date({tag, ".pre"}, 28, 2, 2024 - ydec);
        exit_and_tick(tag, d, mo, y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int early;
        int cnt;

        // Reset values and first tick after release
        @(negedge clk);
        #1;
        chk_time("reset", 0, 0, 0);
        chk_date("reset", 1, 1, 2024);
        chk("reset.field_sel", 32'(field_sel), 32'd0);
        chk("reset.editing", 32'(editing), 32'd0);
        chk("reset.tick", 32'(tick), 32'd0);
        do_reset(1'b0);
        early = 0;
        for (int k = 1; k < CLK_DIV; k++) begin
            @(negedge clk);
            if (tick) early++;
        end
        chk("first.early_tick", 32'(early), 32'd0);
        @(negedge clk);
        chk("first.tick", 32'(tick), 32'd1);
        chk("first.sec", 32'(sec), 32'd1);
        @(negedge clk);
        chk("first.tick_low", 32'(tick), 32'd0);

        // 23:59:59 31/12/9999 rolls to 00:00:00 01/01/0000
        do_reset(1'b1);
        @(negedge clk);
        chk("set.editing", 32'(editing), 32'd1);
        chk("set.field_sel", 32'(field_sel), 32'd0);
        press(0, 1, 0, 1);    press(0, 0, 1, 1);
        press(0, 1, 0, 1);    press(0, 0, 1, 1);
        press(0, 1, 0, 1);    press(0, 0, 1, 1);
        press(0, 1, 0, 1);    press(0, 0, 1, 1);
        press(0, 1, 0, 1);    press(0, 0, 1, 1);
        press(0, 1, 0, 2025);
        chk_time("max.pre", 23, 59, 59);
        chk_date("max.pre", 31, 12, 9999);
        exit_and_tick("max", 1, 1, 0);

        // Leap-year rollovers
        leap_case("leap2023", 1,   1, 3, 2023);
        leap_case("leap2024", 0,   29, 2, 2024);
        leap_case("leap1900", 124, 1, 3, 1900);
        leap_case("leap2000", 24,  29, 2, 2000);

        // Held button acts once; inc+dec cancel; no tick while in SET
        do_reset(1'b1);
        press(0, 0, 1, 2);
        chk("hold.field_sel", 32'(field_sel), 32'd2);
        @(negedge clk);
        btn_dec = 1'b1;
        repeat (10) @(negedge clk);
        btn_dec = 1'b0;
        @(negedge clk);
        chk("hold.sec", 32'(sec), 32'd59);
        chk("hold.min", 32'(min), 32'd0);
        press(1, 1, 0, 1);
        chk("incdec.sec", 32'(sec), 32'd59);
        cnt = 0;
        for (int k = 0; k < 3 * CLK_DIV; k++) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        chk("set.no_tick", 32'(cnt), 32'd0);
        chk("set.frozen_sec", 32'(sec), 32'd59);

        // Field navigation, next+inc together, day clamp on month/year edit
        do_reset(1'b1);
        press(1, 0, 1, 1);
        chk("combo.hour", 32'(hour), 32'd1);
        chk("combo.field_sel", 32'(field_sel), 32'd1);
        press(0, 0, 1, 3);
        press(1, 0, 0, 2);                       // month 3
        press(0, 0, 1, 5);                       // 4 -> 3
        press(0, 1, 0, 1);                       // day 31
        chk_date("mar31", 31, 3, 2024);
        press(0, 0, 1, 3);
        chk("wrap.field_sel", 32'(field_sel), 32'd0);
        press(0, 0, 1, 4);
        chk("next4.field_sel", 32'(field_sel), 32'd4);
        press(0, 1, 0, 1);
        chk_date("clamp.month", 29, 2, 2024);
        press(0, 0, 1, 1);
        press(0, 1, 0, 1);
        chk_date("clamp.year", 28, 2, 2023);
        press(0, 0, 1, 1);
        chk("sel5to0.field_sel", 32'(field_sel), 32'd0);
        press(0, 0, 1, 6);
        chk("next6.field_sel", 32'(field_sel), 32'd0);

        // Asynchronous reset while in SET
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_set.editing", 32'(editing), 32'd0);
        chk("rst_set.field_sel", 32'(field_sel), 32'd0);
        chk_time("rst_set", 0, 0, 0);
        chk_date("rst_set", 1, 1, 2024);
        @(negedge clk);
        rst_n = 1'b1;
        set_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
- Parametrised real-time clock/calendar core that replaces the fixed decade counter.
- Contains an internal prescaler and a binary time/date register set (hh:mm:ss, dd/mm/yyyy) with full Gregorian leap-year handling.
- Adds a RUN/SET state machine so the three push-buttons can edit any field.
- Feeds the downstream BCD / 7-segment display mux; the display is not part of this block.

Parameters:
- CLK_DIV, 50_000_000: clk cycles per one-second tick; legal range is 2 or more.
- RESET_YEAR, 2024: year loaded on reset; range 0..9999.
- RESET_MONTH, 1: month loaded on reset; range 1..12.
- RESET_DAY, 1: day loaded on reset; must be a valid day for RESET_MONTH/RESET_YEAR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- set_mode  in  1  level input; 1 = SET state, 0 = RUN state
- btn_inc  in  1  debounced level; increments the selected field
- btn_dec  in  1  debounced level; decrements the selected field
- btn_next  in  1  debounced level; advances the selected field
- sec  out  6  seconds, 0..59
- min  out  6  minutes, 0..59
- hour  out  5  hours, 0..23
- day  out  5  day, 1..days_in_month
- month  out  4  month, 1..12
- year  out  14  year, 0..9999
- field_sel  out  3  field being edited: 0 hour, 1 min, 2 sec, 3 day, 4 month, 5 year
- editing  out  1  high while in SET state
- tick  out  1  one-cycle pulse, coincident with the cycle in which a RUN-mode second update becomes visible

Behaviour:
- Reset is asynchronous, active-low on rst_n; clk is the clock.
- Reset values:
  - sec = min = hour = 0
  - day = RESET_DAY, month = RESET_MONTH, year = RESET_YEAR
  - field_sel = 0, editing = 0, tick = 0
  - prescaler = 0, button history registers = 0, state = RUN
- Prescaler: counts 0..CLK_DIV-1, only in RUN. The edge at which it equals CLK_DIV-1 is the tick edge:
  - prescaler returns to 0;
  - the time/date fields advance;
  - the tick output is registered high for the next cycle.
- Carry chain on a tick edge, all in a single edge with no intermediate states visible:
  - sec 59 -> 0 carries to min;
  - min 59 -> 0 carries to hour;
  - hour 23 -> 0 carries to day;
  - day == days_in_month -> 1 carries to month;
  - month 12 -> 1 carries to year;
  - year 9999 -> 0.
- days_in_month:
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - Feb: 29 if leap, else 28. Leap means (year%4==0 && year%100!=0) || year%400==0. Year 0 is leap.
- State machine, sampled each edge:
  - RUN -> SET when set_mode==1. On entry: prescaler <= 0, field_sel <= 0, editing <= 1.
  - SET -> RUN when set_mode==0. On exit: prescaler <= 0, editing <= 0. The first tick edge occurs CLK_DIV cycles after the exit edge.
  - A tick is never generated in SET. The time/date fields are frozen except for button edits.
- Buttons:
  - Each button is rising-edge detected internally by one history register. A held button causes exactly one action.
  - Buttons are ignored in RUN, but their history registers still update.
  - btn_next edge: field_sel advances 0 -> 1 -> ... -> 5 -> 0.
  - btn_inc edge / btn_dec edge: the selected field steps ±1 and wraps within its own range only, with no carry into other fields. Ranges: sec/min 0..59, hour 0..23, day 1..days_in_month, month 1..12, year 0..9999.
  - btn_inc and btn_dec edges in the same cycle: no change to the field.
  - btn_next together with inc or dec in the same cycle: the inc/dec applies to the current (old) field_sel, and field_sel advances in the same edge.
- Day clamp: after any month or year edit, if day > new days_in_month, day <= new days_in_month in the same edge. Example: 31/03 with month dec -> 29/02 in a leap year.
- Arithmetic:
  - All fields are unsigned binary.
  - Wrap compares use equality against the range limits, never overflow of the register width.
  - The year modulo for the leap test is computed combinationally from the 14-bit year.
- Reset mid-operation, in either state, returns every register to its reset value immediately.

Test Plan:
- Reset, then release with CLK_DIV=4 -> outputs 00:00:00 01/01/2024. tick first high 4 cycles after release. sec=1 that cycle.
- Start at 23:59:59 31/12/9999, one tick -> 00:00:00 01/01/0000. Single-cycle update, tick high once.
- Leap rollovers:
  - 23:59:59 28/02/2023 + tick -> 01/03/2023.
  - Same at 2024 -> 29/02/2024.
  - 1900 -> 01/03/1900.
  - 2000 -> 29/02/2000.
- SET, field_sel=2, sec=0, one btn_dec pulse held 10 cycles -> sec=59 (single action), min unchanged. btn_inc and btn_dec together -> no change. No tick for 3×CLK_DIV cycles.
- SET, 31/03/2024, btn_next ×4 -> field_sel=4. btn_dec -> month=2, day=29. Then year edit to 2023 -> day=28.
- Leave SET at edge T -> first tick at T+CLK_DIV. btn_next pressed 6 times -> field_sel returns to 0. Assert rst_n low during SET -> editing=0 and fields at reset values.
